// File: rtl/sig_pkg.sv
// Shared encodings for the signal conflict monitor: light codes, fault codes, FSM states.
package sig_pkg;
  typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} light_e;
  typedef enum logic [1:0] {ARM = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_BADCODE  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORTYEL = 3'd4;
  localparam logic [2:0] FC_CLEAR    = 3'd5;

  // Lowest code wins when several checks fire on the same sample.
  function automatic logic [2:0] fc_pick(input logic bad, input logic conf, input logic seq,
                                         input logic sy, input logic clr);
    if (bad)       return FC_BADCODE;
    else if (conf) return FC_CONFLICT;
    else if (seq)  return FC_SEQ;
    else if (sy)   return FC_SHORTYEL;
    else if (clr)  return FC_CLEAR;
    else           return FC_NONE;
  endfunction
endpackage

// File: rtl/sig_road_check.sv
// Per-road sequence checker: tracks previous light code and consecutive YELLOW count.
module sig_road_check
  import sig_pkg::*;
#(
  parameter int MIN_YEL = 3
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       i_arm,
  input  logic       i_run,
  input  logic [1:0] i_code,
  output logic       o_seq_err,
  output logic       o_shortyel_err,
  output logic       o_r2g
);
  localparam int YW = $clog2(MIN_YEL + 1);
  localparam logic [YW-1:0] YMAX = YW'(MIN_YEL);

  logic [1:0]    r_prev;
  logic [YW-1:0] r_yel_cnt;
  logic          w_hold;
  logic          w_step_ok;

  always_comb begin
    w_hold         = (i_code == r_prev);
    w_step_ok      = (r_prev == GREEN  && i_code == YELLOW) ||
                     (r_prev == YELLOW && i_code == RED)    ||
                     (r_prev == RED    && i_code == GREEN);
    o_seq_err      = !(w_hold || w_step_ok);
    o_shortyel_err = (r_prev == YELLOW) && (i_code == RED) && (r_yel_cnt < YMAX);
    o_r2g          = (r_prev == RED) && (i_code == GREEN);
  end

  // Arming presets the yellow count so a yellow already in progress is not flagged.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_prev    <= RED;
      r_yel_cnt <= '0;
    end else if (i_arm) begin
      r_prev    <= i_code;
      r_yel_cnt <= YMAX;
    end else if (i_run) begin
      r_prev <= i_code;
      if (i_code == YELLOW) begin
        if (r_yel_cnt != YMAX) r_yel_cnt <= r_yel_cnt + YW'(1);
      end else begin
        r_yel_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/sig_monitor.sv
// Traffic signal conflict monitor: latches the first fault and blinks flash_red until acked.
// Optional SIG_MON_STATS_EN adds a saturating fault_cnt output.
module sig_monitor
  import sig_pkg::*;
#(
  parameter int MIN_YEL    = 3,
  parameter int MIN_ALLRED = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       ack,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red
`ifdef SIG_MON_STATS_EN
  ,
  output logic [7:0] fault_cnt
`endif
);
  localparam int AW = $clog2(MIN_ALLRED + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [AW-1:0] AMAX    = AW'(MIN_ALLRED);
  localparam logic [FW-1:0] FH_LAST = FW'(FLASH_HALF - 1);

  state_e        r_state, w_next;
  logic [2:0]    r_code;
  logic          r_flash;
  logic [FW-1:0] r_flash_cnt;
  logic [AW-1:0] r_allred;
  logic [1:0]    w_seq, w_sy, w_r2g;
  logic          w_bad, w_conf, w_clr, w_both_red, w_enter;
  logic [2:0]    w_viol;

  sig_road_check #(.MIN_YEL(MIN_YEL)) u_hwy (
    .clock(clock), .clear_n(clear_n), .i_arm(r_state == ARM), .i_run(r_state == RUN),
    .i_code(hwy), .o_seq_err(w_seq[0]), .o_shortyel_err(w_sy[0]), .o_r2g(w_r2g[0]));

  sig_road_check #(.MIN_YEL(MIN_YEL)) u_cntry (
    .clock(clock), .clear_n(clear_n), .i_arm(r_state == ARM), .i_run(r_state == RUN),
    .i_code(cntry), .o_seq_err(w_seq[1]), .o_shortyel_err(w_sy[1]), .o_r2g(w_r2g[1]));

  always_comb begin
    w_bad      = (hwy == 2'd3) || (cntry == 2'd3);
    w_conf     = (hwy != RED) && (cntry != RED);
    w_clr      = (|w_r2g) && (r_allred < AMAX);
    w_both_red = (hwy == RED) && (cntry == RED);
    w_next     = r_state;
    w_viol     = FC_NONE;
    unique case (r_state)
      ARM: begin
        w_viol = fc_pick(w_bad, w_conf, 1'b0, 1'b0, 1'b0);
        w_next = (w_viol != FC_NONE) ? FAULT : RUN;
      end
      RUN: begin
        w_viol = fc_pick(w_bad, w_conf, |w_seq, |w_sy, w_clr);
        if (w_viol != FC_NONE) w_next = FAULT;
      end
      FAULT: if (ack && w_both_red) w_next = ARM;
      default: w_next = ARM;
    endcase
    w_enter = (r_state != FAULT) && (w_next == FAULT);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state     <= ARM;
      r_code      <= FC_NONE;
      r_flash     <= 1'b0;
      r_flash_cnt <= '0;
      r_allred    <= '0;
    end else begin
      r_state <= w_next;
      if (w_enter) begin
        r_code      <= w_viol;
        r_flash     <= 1'b1;
        r_flash_cnt <= '0;
      end else if (r_state == FAULT) begin
        if (w_next == ARM) begin
          r_code  <= FC_NONE;
          r_flash <= 1'b0;
        end else if (r_flash_cnt == FH_LAST) begin
          r_flash_cnt <= '0;
          r_flash     <= ~r_flash;
        end else begin
          r_flash_cnt <= r_flash_cnt + FW'(1);
        end
      end
      // Arming presets the clearance count so an in-progress all-red is honoured.
      if (r_state == ARM) r_allred <= AMAX;
      else if (r_state == RUN) begin
        if (!w_both_red) r_allred <= '0;
        else if (r_allred != AMAX) r_allred <= r_allred + AW'(1);
      end
    end
  end

`ifdef SIG_MON_STATS_EN
  logic [7:0] r_fault_cnt;
  always_ff @(posedge clock) begin
    if (!clear_n) r_fault_cnt <= '0;
    else if (w_enter && r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
  end
  assign fault_cnt = r_fault_cnt;
`endif

  assign fault      = (r_state == FAULT);
  assign fault_code = r_code;
  assign flash_red  = r_flash;
endmodule

// File: tb/tb_sig_monitor.sv
// Scoreboard bench for sig_monitor: directed samples push expectations, a monitor pops and compares.
module tb_sig_monitor;
  localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2, X = 2'd3;

  typedef struct {
    logic       f;
    logic [2:0] code;
    int         fl;
    int         cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic [1:0] hwy = R, cntry = R;
  logic       ack = 1'b0;
  logic       fault, flash_red;
  logic [2:0] fault_code;
`ifdef SIG_MON_STATS_EN
  logic [7:0] fault_cnt;
`endif

  exp_t  q[$];
  string nq[$];
  exp_t  mon_e;
  string mon_n;
  int    vectors = 0, miscompares = 0, nf = 0;
  int    fl_pat[11] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

  always #5 clock = ~clock;

  sig_monitor dut (
    .clock(clock), .clear_n(clear_n), .hwy(hwy), .cntry(cntry), .ack(ack),
    .fault(fault), .fault_code(fault_code), .flash_red(flash_red)
`ifdef SIG_MON_STATS_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  task automatic step(input string nm, input logic [1:0] h, input logic [1:0] c,
                      input logic a, input logic cl, input logic ef,
                      input logic [2:0] ec, input int efl, input int ecnt);
    exp_t e;
    @(negedge clock);
    hwy = h; cntry = c; ack = a; clear_n = cl;
    e.f = ef; e.code = ec; e.fl = efl; e.cnt = ecnt;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        logic bad;
        mon_e = q.pop_front();
        mon_n = nq.pop_front();
        vectors++;
        bad = (fault !== mon_e.f) || (fault_code !== mon_e.code);
        if (mon_e.fl >= 0 && flash_red !== mon_e.fl[0]) bad = 1'b1;
`ifdef SIG_MON_STATS_EN
        if (mon_e.cnt >= 0 && fault_cnt !== 8'(mon_e.cnt)) begin
          bad = 1'b1;
          $display("FAIL %s fault_cnt: got %0d want %0d", mon_n, fault_cnt, mon_e.cnt);
        end
`endif
        if (bad) begin
          miscompares++;
          $display("FAIL %s: got fault=%0b code=%0d flash=%0b, want fault=%0b code=%0d flash=%0d",
                   mon_n, fault, fault_code, flash_red, mon_e.f, mon_e.code, mon_e.fl);
        end
      end
    end
  end

  initial begin
    repeat (2) step("reset", R, R, 0, 0, 0, 0, 0, 0);
    // Full legal cycle; arming edge samples G/R.
    step("arm", G, R, 0, 1, 0, 0, 0, nf);
    repeat (9) step("legal_hg", G, R, 0, 1, 0, 0, 0, nf);
    repeat (3) step("legal_hy", Y, R, 0, 1, 0, 0, 0, nf);
    repeat (2) step("legal_rr", R, R, 0, 1, 0, 0, 0, nf);
    repeat (5) step("legal_cg", R, G, 0, 1, 0, 0, 0, nf);
    repeat (3) step("legal_cy", R, Y, 0, 1, 0, 0, 0, nf);
    repeat (2) step("legal_rr2", R, R, 0, 1, 0, 0, 0, nf);
    step("legal_hg2", G, R, 0, 1, 0, 0, 0, nf);
    step("run_ack", G, R, 1, 1, 0, 0, 0, nf);
    // Conflict and flash pattern 1111 0000 1111.
    nf = 1;
    step("conflict", G, G, 0, 1, 1, 2, 1, nf);
    foreach (fl_pat[i]) step("flash", G, R, 0, 1, 1, 2, fl_pat[i], nf);
    step("ignore_viol", X, G, 0, 1, 1, 2, -1, nf);
    step("ack_green", G, R, 1, 1, 1, 2, -1, nf);
    step("ack_rr", R, R, 1, 1, 0, 0, 0, nf);
    step("rearm", R, R, 0, 1, 0, 0, 0, nf);
    // Bad code beats conflict.
    nf = 2;
    step("badcode", X, G, 0, 1, 1, 1, 1, nf);
    step("ack2", R, R, 1, 1, 0, 0, 0, nf);
    step("rearm2", R, R, 0, 1, 0, 0, 0, nf);
    // Short yellow.
    step("sy_g", G, R, 0, 1, 0, 0, 0, nf);
    repeat (2) step("sy_y", Y, R, 0, 1, 0, 0, 0, nf);
    nf = 3;
    step("shortyel", R, R, 0, 1, 1, 4, 1, nf);
    step("ack3", R, R, 1, 1, 0, 0, 0, nf);
    step("rearm3", R, R, 0, 1, 0, 0, 0, nf);
    // Green straight to red.
    step("seq_g", G, R, 0, 1, 0, 0, 0, nf);
    nf = 4;
    step("seq", R, R, 0, 1, 1, 3, 1, nf);
    step("ack4", R, R, 1, 1, 0, 0, 0, nf);
    step("rearm4", R, R, 0, 1, 0, 0, 0, nf);
    // Short all-red clearance.
    step("clr_g", G, R, 0, 1, 0, 0, 0, nf);
    repeat (3) step("clr_y", Y, R, 0, 1, 0, 0, 0, nf);
    step("clr_rr", R, R, 0, 1, 0, 0, 0, nf);
    nf = 5;
    step("clear", R, G, 0, 1, 1, 5, 1, nf);
    // Reset mid-fault, then a conflict caught by the arming check.
    nf = 0;
    step("clr_mid", R, G, 0, 0, 0, 0, 0, nf);
    nf = 1;
    step("arm_conf", G, G, 0, 1, 1, 2, 1, nf);
    nf = 0;
    step("clr_end", R, R, 0, 0, 0, 0, 0, nf);
    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
